// File: rtl/atm_rewrite_pkg.sv
// Shared definitions for the ATM cell header rewrite stage.
//   CELL_BYTES / HDR_BYTES : UNI cell geometry
//   HEC_POLY / HEC_COSET   : HEC CRC-8 generator and output coset
//   state_t                : rewriter control states
package atm_rewrite_pkg;

  localparam int         CELL_BYTES = 53;
  localparam int         HDR_BYTES  = 5;
  localparam logic [7:0] HEC_POLY   = 8'h07;
  localparam logic [7:0] HEC_COSET  = 8'h55;

  typedef enum logic [2:0] {
    COLLECT,
    LOOKUP,
    EMIT,
    PASS,
    DROP
  } state_t;

endpackage

// File: rtl/atm_hec_gen.sv
// Combinational ATM HEC generator.
//   hdr : header bytes b0..b3, b0 in [31:24]
//   hec : CRC-8 (x^8+x^2+x+1, init 0, MSB first) of hdr, XOR coset
module atm_hec_gen
  import atm_rewrite_pkg::*;
(
  input  logic [31:0] hdr,
  output logic [7:0]  hec
);

  logic [7:0] crc;

  // Bit-serial LFSR unrolled over all 32 header bits.
  always_comb begin
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      if (crc[7] ^ hdr[i]) crc = {crc[6:0], 1'b0} ^ HEC_POLY;
      else                 crc = {crc[6:0], 1'b0};
    end
    hec = crc ^ HEC_COSET;
  end

endmodule

// File: rtl/atm_cell_rewriter.sv
// ATM UNI cell header rewriter / forwarder.
// Collects a 5-byte header, checks HEC, looks up the VPI table, then either
// emits the rewritten header and passes the 48 payload bytes through, or
// swallows the payload.
//   clk, rst                        : clock, synchronous active-high reset
//   in_data/in_sop/in_valid/in_ready: receive byte stream
//   lut_addr / lut_rd_data          : VPI table read port (combinational)
//   out_data/sop/eop/fwd/valid/ready: transmit byte stream + forwarding mask
//   cnt_fwd/cnt_hec_err/cnt_unrouted: saturating cell statistics
module atm_cell_rewriter
  import atm_rewrite_pkg::*;
#(
  parameter int NumTx = 4,
  parameter int CntW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_sop,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         lut_addr,
  input  logic [NumTx+7:0]   lut_rd_data,
  output logic [7:0]         out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic [NumTx-1:0]   out_fwd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CntW-1:0]    cnt_fwd,
  output logic [CntW-1:0]    cnt_hec_err,
  output logic [CntW-1:0]    cnt_unrouted
);

  typedef struct packed {
    logic [NumTx-1:0] fwd;
    logic [7:0]       vpi;
  } lut_ent_t;

  localparam logic [5:0] HDR_LAST = 6'(HDR_BYTES - 1);
  localparam logic [5:0] PAY_LAST = 6'(CELL_BYTES - HDR_BYTES - 1);

  state_t           state, state_d;
  logic [5:0]       idx, idx_d;      // header slot or payload byte, per state
  logic [5:0]       wr_slot;
  logic [31:0]      hdr;             // received b0..b3
  logic [7:0]       hec_rx;          // received b4
  logic [7:0]       vpi_new;
  logic [NumTx-1:0] fwd_q;
  lut_ent_t         ent;
  logic [31:0]      hdr_tx;
  logic [7:0]       hec_calc, hec_tx;
  logic             hdr_we, lut_ld, inc_fwd, inc_hec, inc_unr;

  assign ent      = lut_rd_data;
  assign lut_addr = hdr[27:20];
  assign hdr_tx   = {hdr[31:28], vpi_new, hdr[19:0]};
  assign out_fwd  = fwd_q;
  // A start-of-cell byte always lands in b0, wherever collection was.
  assign wr_slot  = in_sop ? 6'd0 : idx;

  atm_hec_gen u_hec_chk (.hdr(hdr),    .hec(hec_calc));
  atm_hec_gen u_hec_gen (.hdr(hdr_tx), .hec(hec_tx));

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    hdr_we    = 1'b0;
    lut_ld    = 1'b0;
    inc_fwd   = 1'b0;
    inc_hec   = 1'b0;
    inc_unr   = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_sop) begin
            hdr_we = 1'b1;
            idx_d  = 6'd1;
          end else if (idx != 6'd0) begin   // idx 0 without sop: hunting
            hdr_we = 1'b1;
            if (idx == HDR_LAST) begin
              idx_d   = 6'd0;
              state_d = LOOKUP;
            end else begin
              idx_d = idx + 6'd1;
            end
          end
        end
      end
      LOOKUP: begin
        if (hec_calc != hec_rx) begin
          state_d = DROP;
          inc_hec = 1'b1;
        end else if (ent.fwd == '0) begin
          state_d = DROP;
          inc_unr = 1'b1;
        end else begin
          state_d = EMIT;
          lut_ld  = 1'b1;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_sop   = (idx == 6'd0);
        case (idx)
          6'd0:    out_data = hdr_tx[31:24];
          6'd1:    out_data = hdr_tx[23:16];
          6'd2:    out_data = hdr_tx[15:8];
          6'd3:    out_data = hdr_tx[7:0];
          default: out_data = hec_tx;
        endcase
        if (out_ready) begin
          if (idx == HDR_LAST) begin
            idx_d   = 6'd0;
            state_d = PASS;
          end else begin
            idx_d = idx + 6'd1;
          end
        end
      end
      PASS: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        out_data  = in_data;
        out_eop   = (idx == PAY_LAST);
        if (in_valid && out_ready) begin
          if (idx == PAY_LAST) begin
            idx_d   = 6'd0;
            state_d = COLLECT;
            inc_fwd = 1'b1;
          end else begin
            idx_d = idx + 6'd1;
          end
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (idx == PAY_LAST) begin
            idx_d   = 6'd0;
            state_d = COLLECT;
          end else begin
            idx_d = idx + 6'd1;
          end
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = 6'd0;
      end
    endcase
    // Nothing transfers in either direction while reset is held.
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      idx          <= 6'd0;
      hdr          <= 32'h0;
      hec_rx       <= 8'h00;
      vpi_new      <= 8'h00;
      fwd_q        <= '0;
      cnt_fwd      <= '0;
      cnt_hec_err  <= '0;
      cnt_unrouted <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (hdr_we) begin
        case (wr_slot)
          6'd0:    hdr[31:24] <= in_data;
          6'd1:    hdr[23:16] <= in_data;
          6'd2:    hdr[15:8]  <= in_data;
          6'd3:    hdr[7:0]   <= in_data;
          default: hec_rx     <= in_data;
        endcase
      end
      // Mask only changes for cells that will actually be emitted.
      if (lut_ld) begin
        fwd_q   <= ent.fwd;
        vpi_new <= ent.vpi;
      end
      if (inc_fwd && cnt_fwd != '1)      cnt_fwd      <= cnt_fwd + CntW'(1);
      if (inc_hec && cnt_hec_err != '1)  cnt_hec_err  <= cnt_hec_err + CntW'(1);
      if (inc_unr && cnt_unrouted != '1) cnt_unrouted <= cnt_unrouted + CntW'(1);
    end
  end

endmodule
